// File: rtl/sram_axi_burst_bridge_pkg.sv
// Shared AXI encodings, bridge FSM states and a size-code helper for the
// cache-to-AXI burst bridge.
package sram_axi_burst_bridge_pkg;

    localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR  = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR  = 2'b11;
    localparam logic [2:0] AXI_SIZE_1B      = 3'd0;
    localparam logic [2:0] AXI_SIZE_2B      = 3'd1;
    localparam logic [2:0] AXI_SIZE_4B      = 3'd2;
    localparam logic [3:0] AXI_CACHE_NORMAL = 4'b0011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW,
        ST_W,
        ST_B
    } state_e;

    function automatic logic [2:0] size_code(input int bytes);
        return 3'($clog2(bytes));
    endfunction

endpackage

// File: rtl/sram_axi_burst_bridge_beat_counter.sv
// Beat counter shared by the read and write data phases: loaded with beats-1
// on request accept, advances per data fire, flags the final beat and wraps.
module sram_axi_burst_bridge_beat_counter #(
    parameter int LEN_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    input  logic                 fire_i,
    output logic                 last_o
);

    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] count_q, count_d;

    assign last_o = (count_q == len_q);

    always_comb begin
        len_d   = len_q;
        count_d = count_q;
        if (load_i) begin
            len_d   = len_i;
            count_d = '0;
        end else if (fire_i) begin
            count_d = last_o ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q   <= '0;
            count_q <= '0;
        end else begin
            len_q   <= len_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sram_axi_burst_bridge.sv
// Single-outstanding bridge from a cache request port to an AXI master with
// INCR bursts; read/write beats stream straight through to the AXI channels.
module sram_axi_burst_bridge
    import sram_axi_burst_bridge_pkg::*;
#(
    parameter int                 ADDR_WIDTH = 32,
    parameter int                 DATA_WIDTH = 32,
    parameter int                 ID_WIDTH   = 4,
    parameter logic [ID_WIDTH-1:0] AXI_ID    = '0,
    parameter int                 MAX_BURST  = 8,
    localparam int                STRB_WIDTH = DATA_WIDTH / 8,
    localparam int                LEN_WIDTH  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [LEN_WIDTH-1:0]  req_len_i,
    input  logic [2:0]            req_size_i,
    input  logic                  wr_valid_i,
    output logic                  wr_ready_o,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [STRB_WIDTH-1:0] wr_strb_i,
    output logic                  rd_valid_o,
    input  logic                  rd_ready_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_last_o,
    output logic                  rd_err_o,
    output logic                  done_valid_o,
    output logic                  done_err_o,
    output logic [ID_WIDTH-1:0]   arid_o,
    output logic [ADDR_WIDTH-1:0] araddr_o,
    output logic [7:0]            arlen_o,
    output logic [2:0]            arsize_o,
    output logic [1:0]            arburst_o,
    output logic [1:0]            arlock_o,
    output logic [3:0]            arcache_o,
    output logic [2:0]            arprot_o,
    output logic                  arvalid_o,
    input  logic                  arready_i,
    input  logic [ID_WIDTH-1:0]   rid_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic [1:0]            rresp_i,
    input  logic                  rlast_i,
    input  logic                  rvalid_i,
    output logic                  rready_o,
    output logic [ID_WIDTH-1:0]   awid_o,
    output logic [ADDR_WIDTH-1:0] awaddr_o,
    output logic [7:0]            awlen_o,
    output logic [2:0]            awsize_o,
    output logic [1:0]            awburst_o,
    output logic [1:0]            awlock_o,
    output logic [3:0]            awcache_o,
    output logic [2:0]            awprot_o,
    output logic                  awvalid_o,
    input  logic                  awready_i,
    output logic [ID_WIDTH-1:0]   wid_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [STRB_WIDTH-1:0] wstrb_o,
    output logic                  wlast_o,
    output logic                  wvalid_o,
    input  logic                  wready_i,
    input  logic [ID_WIDTH-1:0]   bid_i,
    input  logic [1:0]            bresp_i,
    input  logic                  bvalid_i,
    output logic                  bready_o
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [2:0]            size_q, size_d;
    logic                  err_q, err_d;
    logic                  alive_q;

    logic req_fire, r_fire, w_fire, cnt_last, r_beat_err, b_err;

    // alive_q holds req_ready low for the first cycle after reset release
    assign req_ready_o = (state_q == ST_IDLE) && alive_q;
    assign req_fire    = req_valid_i && req_ready_o;

    assign rready_o   = (state_q == ST_R) && rd_ready_i;
    assign r_fire     = rvalid_i && rready_o;
    assign rd_valid_o = (state_q == ST_R) && rvalid_i;
    assign rd_data_o  = (state_q == ST_R) ? rdata_i : '0;
    assign rd_last_o  = (state_q == ST_R) && rlast_i;
    assign rd_err_o   = rd_valid_o && ((rresp_i != AXI_RESP_OKAY) || (rid_i != AXI_ID));
    // An rlast that disagrees with the beat count marks the whole burst bad
    assign r_beat_err = r_fire && ((rresp_i != AXI_RESP_OKAY) || (rid_i != AXI_ID)
                                   || (rlast_i != cnt_last));

    assign wvalid_o   = (state_q == ST_W) && wr_valid_i;
    assign wr_ready_o = (state_q == ST_W) && wready_i;
    assign w_fire     = wvalid_o && wready_i;
    assign wlast_o    = (state_q == ST_W) && cnt_last;
    assign wid_o      = AXI_ID;
    assign wdata_o    = wr_data_i;
    assign wstrb_o    = wr_strb_i;

    assign bready_o = (state_q == ST_B);
    assign b_err    = (bresp_i != AXI_RESP_OKAY) || (bid_i != AXI_ID);

    assign done_valid_o = (r_fire && rlast_i) || (bvalid_i && bready_o);
    assign done_err_o   = done_valid_o && (err_q || ((state_q == ST_R) ? r_beat_err : b_err));

    assign arid_o    = AXI_ID;
    assign araddr_o  = addr_q;
    assign arlen_o   = 8'(len_q);
    assign arsize_o  = size_q;
    assign arburst_o = AXI_BURST_INCR;
    assign arlock_o  = 2'b00;
    assign arcache_o = AXI_CACHE_NORMAL;
    assign arprot_o  = 3'b000;
    assign arvalid_o = (state_q == ST_AR);

    assign awid_o    = AXI_ID;
    assign awaddr_o  = addr_q;
    assign awlen_o   = 8'(len_q);
    assign awsize_o  = size_q;
    assign awburst_o = AXI_BURST_INCR;
    assign awlock_o  = 2'b00;
    assign awcache_o = AXI_CACHE_NORMAL;
    assign awprot_o  = 3'b000;
    assign awvalid_o = (state_q == ST_AW);

    sram_axi_burst_bridge_beat_counter #(
        .LEN_WIDTH (LEN_WIDTH)
    ) u_beat_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (req_fire),
        .len_i  (req_len_i),
        .fire_i (r_fire || w_fire),
        .last_o (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: if (req_fire) begin
                addr_d  = req_addr_i;
                len_d   = req_len_i;
                size_d  = req_size_i;
                err_d   = 1'b0;
                state_d = req_write_i ? ST_AW : ST_AR;
            end
            ST_AR: if (arready_i) state_d = ST_R;
            ST_R: begin
                if (r_beat_err) err_d = 1'b1;
                if (r_fire && rlast_i) state_d = ST_IDLE;
            end
            ST_AW: if (awready_i) state_d = ST_W;
            ST_W:  if (w_fire && cnt_last) state_d = ST_B;
            ST_B:  if (bvalid_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            err_q   <= 1'b0;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            err_q   <= err_d;
            alive_q <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    localparam logic [2:0] FULL_SIZE = size_code(STRB_WIDTH);
    logic [12:0] burst_end;
    assign burst_end = 13'(req_addr_i[11:0]) + ((13'(req_len_i) + 13'd1) << req_size_i);

    // Requester contract: no 4 KB crossing, size-aligned, full size for bursts
    always @(posedge clk) begin
        if (rst_n && req_fire) begin
            assert (burst_end <= 13'd4096);
            assert ((req_addr_i[6:0] & ((7'd1 << req_size_i) - 7'd1)) == 7'd0);
            assert ((req_len_i == '0) || (req_size_i == FULL_SIZE));
        end
    end
`endif

endmodule

// File: tb/tb_sram_axi_burst_bridge.sv
// Directed bench for sram_axi_burst_bridge: table of single transactions plus
// hand sequences for throttled, stalled, reset-interrupted and back-to-back cases.
module tb_sram_axi_burst_bridge;
    import sram_axi_burst_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_len, req_size;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        rd_valid, rd_ready, rd_last, rd_err;
    logic [31:0] rd_data;
    logic        done_valid, done_err;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
    logic [3:0]  arcache, awcache, wstrb;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    sram_axi_burst_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_len_i(req_len), .req_size_i(req_size),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data), .wr_strb_i(wr_strb),
        .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
        .rd_last_o(rd_last), .rd_err_o(rd_err),
        .done_valid_o(done_valid), .done_err_o(done_err),
        .arid_o(arid), .araddr_o(araddr), .arlen_o(arlen), .arsize_o(arsize),
        .arburst_o(arburst), .arlock_o(arlock), .arcache_o(arcache), .arprot_o(arprot),
        .arvalid_o(arvalid), .arready_i(arready),
        .rid_i(rid), .rdata_i(rdata), .rresp_i(rresp), .rlast_i(rlast),
        .rvalid_i(rvalid), .rready_o(rready),
        .awid_o(awid), .awaddr_o(awaddr), .awlen_o(awlen), .awsize_o(awsize),
        .awburst_o(awburst), .awlock_o(awlock), .awcache_o(awcache), .awprot_o(awprot),
        .awvalid_o(awvalid), .awready_i(awready),
        .wid_o(wid), .wdata_o(wdata), .wstrb_o(wstrb), .wlast_o(wlast),
        .wvalid_o(wvalid), .wready_i(wready),
        .bid_i(bid), .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  len;
        logic [2:0]  size;
        int          wait_cyc;
        logic [1:0]  resp;
        logic [3:0]  id;
        logic        exp_beat_err;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input int i, input vec_t v);
        string p;
        p = $sformatf("v%0d", i);
        $display("txn %0d: %s addr=%h len=%0d size=%0d", i, v.wr ? "WRITE" : "READ", v.addr, v.len, v.size);
        @(negedge clk);
        req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_len = v.len; req_size = v.size;
        #1 chk({p, " req_ready"}, req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 0; c <= v.wait_cyc; c++) begin
            if (c > 0) @(negedge clk);
            if (v.wr) awready = (c == v.wait_cyc); else arready = (c == v.wait_cyc);
            #1 chk({p, " addr valid held"}, v.wr ? awvalid : arvalid, 1);
        end
        chk({p, " addr"}, v.wr ? awaddr : araddr, v.addr);
        chk({p, " len"}, v.wr ? awlen : arlen, {5'd0, v.len});
        chk({p, " size"}, v.wr ? awsize : arsize, v.size);
        chk({p, " burst/lock/cache/prot"}, v.wr ? {awburst, awlock, awcache, awprot}
                                                : {arburst, arlock, arcache, arprot}, 11'b01_00_0011_000);
        chk({p, " id"}, v.wr ? awid : arid, 0);
        @(negedge clk);
        arready = 1'b0; awready = 1'b0;
        #1 chk({p, " addr valid drop"}, v.wr ? awvalid : arvalid, 0);
        if (!v.wr) begin
            for (int b = 0; b <= int'(v.len); b++) begin
                @(negedge clk);
                rvalid = 1'b1; rd_ready = 1'b1; rdata = {v.addr[15:0], 16'(b)};
                rlast = (b == int'(v.len)); rresp = v.resp; rid = v.id;
                #1;
                chk({p, " rd_valid"}, rd_valid, 1);
                chk({p, " rready"}, rready, 1);
                chk({p, " rd_data"}, rd_data, {v.addr[15:0], 16'(b)});
                chk({p, " rd_last"}, rd_last, b == int'(v.len));
                chk({p, " rd_err"}, rd_err, v.exp_beat_err);
                chk({p, " done_valid"}, done_valid, b == int'(v.len));
                if (b == int'(v.len)) chk({p, " done_err"}, done_err, v.exp_err);
            end
            @(negedge clk);
            rvalid = 1'b0; rlast = 1'b0; rd_ready = 1'b0; rresp = 2'b00; rid = 4'h0;
        end else begin
            for (int b = 0; b <= int'(v.len); b++) begin
                @(negedge clk);
                wr_valid = 1'b1; wready = 1'b1; wr_data = 32'hA500_0000 | b; wr_strb = 4'hF ^ 4'(b);
                #1;
                chk({p, " wvalid"}, wvalid, 1);
                chk({p, " wr_ready"}, wr_ready, 1);
                chk({p, " wdata"}, wdata, 32'hA500_0000 | b);
                chk({p, " wstrb"}, wstrb, 4'hF ^ 4'(b));
                chk({p, " wlast"}, wlast, b == int'(v.len));
                chk({p, " wid"}, wid, 0);
            end
            @(negedge clk);
            wr_valid = 1'b0; wready = 1'b0;
            #1 chk({p, " wvalid after burst"}, wvalid, 0);
            chk({p, " bready"}, bready, 1);
            @(negedge clk);
            bvalid = 1'b1; bresp = v.resp; bid = v.id;
            #1 chk({p, " done_valid"}, done_valid, 1);
            chk({p, " done_err"}, done_err, v.exp_err);
            @(negedge clk);
            bvalid = 1'b0; bresp = 2'b00; bid = 4'h0;
        end
        #1 chk({p, " done pulse ends"}, done_valid, 0);
        chk({p, " back to idle"}, req_ready, 1);
    endtask

    initial begin
        int fires;
        int k;
        logic [31:0] got[$];

        req_valid = 0; req_write = 0; req_addr = 0; req_len = 0; req_size = 0;
        wr_valid = 0; wr_data = 0; wr_strb = 0; rd_ready = 0;
        arready = 0; awready = 0; wready = 0;
        rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
        bid = 0; bresp = 0; bvalid = 0;

        //           wr    addr          len   size         wait resp             id    berr  err
        vecs[0] = '{1'b0, 32'h1000_0020, 3'd7, AXI_SIZE_4B, 3, AXI_RESP_OKAY,   4'h0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 32'h2000_0003, 3'd0, AXI_SIZE_1B, 0, AXI_RESP_SLVERR, 4'h0, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 32'h3000_0040, 3'd3, AXI_SIZE_4B, 1, AXI_RESP_OKAY,   4'h0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 32'h3000_0102, 3'd0, AXI_SIZE_2B, 0, AXI_RESP_DECERR, 4'h0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 32'h4000_0008, 3'd1, AXI_SIZE_4B, 0, AXI_RESP_OKAY,   4'h5, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 32'h5000_0000, 3'd7, AXI_SIZE_4B, 2, AXI_RESP_OKAY,   4'h3, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 32'h6000_0F00, 3'd3, AXI_SIZE_4B, 1, AXI_RESP_DECERR, 4'h0, 1'b1, 1'b1};

        // Reset state
        @(negedge clk);
        #1;
        chk("reset req_ready", req_ready, 0);
        chk("reset valids", {arvalid, awvalid, wvalid, rd_valid, done_valid}, 0);
        chk("reset readies", {rready, bready, wr_ready}, 0);
        chk("reset rd outputs", {rd_data, rd_last, rd_err, done_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("req_ready just after release", req_ready, 0);
        @(negedge clk);
        #1 chk("req_ready after release", req_ready, 1);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Write len=3 with wready toggling 1010
        $display("txn t2: WRITE len=3 wready toggling");
        @(negedge clk);
        req_valid = 1; req_write = 1; req_addr = 32'h6100_0000; req_len = 3; req_size = AXI_SIZE_4B;
        @(negedge clk);
        req_valid = 0; awready = 1;
        #1 chk("t2 awvalid", awvalid, 1);
        @(negedge clk);
        awready = 0; wr_valid = 1; wr_strb = 4'hF;
        fires = 0;
        for (int c = 0; c < 20 && fires < 4; c++) begin
            if (c > 0) @(negedge clk);
            wready = (c % 2 == 0); wr_data = 32'hB000_0000 | fires;
            #1;
            if (!wready) chk("t2 wr_ready follows wready", wr_ready, 0);
            if (wvalid && wready) begin
                fires++;
                chk("t2 wlast on beat", wlast, fires == 4);
            end
        end
        chk("t2 beat count", fires, 4);
        @(negedge clk);
        wready = 1;
        #1 chk("t2 no extra beat", wvalid, 0);
        @(negedge clk);
        wr_valid = 0; wready = 0; bvalid = 1; bresp = AXI_RESP_OKAY; bid = 0;
        #1 chk("t2 done_valid", done_valid, 1);
        chk("t2 done_err", done_err, 0);
        @(negedge clk);
        bvalid = 0;

        // Read len=7 with rd_ready low for 5 cycles mid-burst
        $display("txn t4: READ len=7 with rd_ready stall");
        @(negedge clk);
        req_valid = 1; req_write = 0; req_addr = 32'h7000_0000; req_len = 7; req_size = AXI_SIZE_4B;
        @(negedge clk);
        req_valid = 0; arready = 1;
        @(negedge clk);
        arready = 0;
        k = 0;
        for (int c = 0; c < 40 && k < 8; c++) begin
            @(negedge clk);
            rd_ready = !(c >= 3 && c < 8);
            rvalid = 1; rdata = 32'(k); rlast = (k == 7); rresp = AXI_RESP_OKAY; rid = 0;
            #1;
            if (!rd_ready) chk("t4 rready low in stall", rready, 0);
            if (rready) begin
                got.push_back(rd_data);
                k++;
            end
        end
        @(negedge clk);
        rvalid = 0; rlast = 0; rd_ready = 0;
        #1 chk("t4 beats received", got.size(), 8);
        for (int j = 0; j < got.size(); j++) chk($sformatf("t4 beat %0d data", j), got[j], j);
        chk("t4 idle after burst", req_ready, 1);

        // Reset asserted during write beat 2
        $display("txn t5: WRITE len=3 reset during beat 2");
        @(negedge clk);
        req_valid = 1; req_write = 1; req_addr = 32'h8000_0000; req_len = 3; req_size = AXI_SIZE_4B;
        @(negedge clk);
        req_valid = 0; awready = 1;
        @(negedge clk);
        awready = 0; wr_valid = 1; wready = 1;
        @(negedge clk);
        wready = 0;
        #1 chk("t5 wvalid before reset", wvalid, 1);
        #1 rst_n = 1'b0;
        #1 chk("t5 valids drop on reset", {wvalid, awvalid, arvalid, rd_valid, done_valid, bready, req_ready}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("t5 req_ready just after release", req_ready, 0);
        @(negedge clk);
        #1 chk("t5 req_ready after release", req_ready, 1);
        chk("t5 no write activity", {wvalid, awvalid}, 0);
        wr_valid = 0;

        // Back-to-back read then write with req_valid held; bid mismatch
        $display("txn t6: READ then WRITE back-to-back");
        @(negedge clk);
        req_valid = 1; req_write = 0; req_addr = 32'h9000_0000; req_len = 0; req_size = AXI_SIZE_4B;
        #1 chk("t6 first accept", req_ready, 1);
        @(negedge clk);
        req_write = 1; req_addr = 32'h9000_0100; req_len = 1; arready = 1;
        #1 chk("t6 busy in AR", req_ready, 0);
        chk("t6 arvalid", arvalid, 1);
        @(negedge clk);
        arready = 0; rvalid = 1; rd_ready = 1; rdata = 32'h1234_5678; rlast = 1;
        rresp = AXI_RESP_OKAY; rid = 0; bvalid = 1; bid = 0;
        #1 chk("t6 stray bvalid ignored", bready, 0);
        chk("t6 read done", done_valid, 1);
        chk("t6 read done_err", done_err, 0);
        chk("t6 busy on done", req_ready, 0);
        @(negedge clk);
        rvalid = 0; rlast = 0; rd_ready = 0; bvalid = 0;
        #1 chk("t6 second accept after done", req_ready, 1);
        @(negedge clk);
        req_valid = 0; awready = 1;
        #1 chk("t6 awvalid", awvalid, 1);
        chk("t6 awaddr", awaddr, 32'h9000_0100);
        chk("t6 awlen", awlen, 1);
        @(negedge clk);
        awready = 0; wr_valid = 1; wready = 1;
        for (int b = 0; b < 2; b++) begin
            if (b > 0) @(negedge clk);
            wr_data = 32'hC000_0000 | b;
            #1 chk($sformatf("t6 wlast beat %0d", b), wlast, b == 1);
        end
        @(negedge clk);
        wr_valid = 0; wready = 0; bvalid = 1; bresp = AXI_RESP_OKAY; bid = 4'h9;
        #1 chk("t6 write done", done_valid, 1);
        chk("t6 bid mismatch done_err", done_err, 1);
        @(negedge clk);
        bvalid = 0; bid = 0;
        #1 chk("t6 idle", req_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
